// File: rtl/pmem_responder.sv
// Memory-side responder for the pmem_* line interface: one line read/write at a time, fixed LATENCY.
// Optional protocol checking is built when PMEM_PROTO_CHECK_EN is defined; otherwise proto_err is tied low.
module pmem_responder #(
    parameter int LINE_BITS  = 256,
    parameter int INDEX_BITS = 6,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic                 proto_err
);

    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, next_state;
    logic [3:0]            cnt, cnt_next;
    logic                  lat_write;
    logic [INDEX_BITS-1:0] lat_index;
    logic [LINE_BITS-1:0]  lat_wdata;
    logic [LINE_BITS-1:0]  mem [DEPTH];

    logic [INDEX_BITS-1:0] req_index;
    logic                  req_any;
    logic                  commit;
    logic                  commit_write;
    logic [INDEX_BITS-1:0] commit_index;
    logic [LINE_BITS-1:0]  commit_wdata;
    logic                  unused_addr_bits;

    assign req_index        = pmem_address[INDEX_BITS+4:5];
    assign req_any          = pmem_read | pmem_write;
    assign unused_addr_bits = ^{pmem_address[31:INDEX_BITS+5], pmem_address[4:0]};

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_any) begin
                    cnt_next   = 4'(LATENCY - 1);
                    next_state = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The commit edge is the one entering RESP; with LATENCY==1 that is the acceptance edge itself,
    // so the live request is used instead of the not-yet-latched copy.
    assign commit       = (next_state == RESP);
    assign commit_write = (state == IDLE) ? pmem_write : lat_write;
    assign commit_index = (state == IDLE) ? req_index  : lat_index;
    assign commit_wdata = (state == IDLE) ? pmem_wdata : lat_wdata;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            lat_write  <= 1'b0;
            lat_index  <= '0;
            lat_wdata  <= '0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            pmem_resp <= commit;
            if (state == IDLE && req_any) begin
                lat_write <= pmem_write;
                lat_index <= req_index;
                lat_wdata <= pmem_wdata;
            end
            if (commit && !commit_write) pmem_rdata <= mem[commit_index];
        end
    end

    // NOTE: the line array has no reset; contents are undefined until written and survive rst.
    always_ff @(posedge clk) begin
        if (!rst && commit && commit_write) mem[commit_index] <= commit_wdata;
    end

`ifdef PMEM_PROTO_CHECK_EN
    logic err_q;
    logic op_dropped;

    assign op_dropped = lat_write ? !pmem_write : !pmem_read;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == IDLE && pmem_read && pmem_write) ||
                     (state != IDLE && (op_dropped || req_index != lat_index))) begin
            err_q <= 1'b1;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
